scan_chain_engine: RTL

//  Parametrised internal driver for the tiny-design scan chain; successor to the fixed 8-IO internal driver.
//  Per refresh: shifts one input word to the selected design, pulses latch, loads all design outputs,

---
 rtl/scan_chain_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/scan_chain_engine.sv
// Scan chain driver: shifts an input word into one design, latches it, loads all outputs and reads one word back.
// Optional SCAN_CHANGE_DETECT_EN adds out_changed, pulsed with done when the captured word differs from the last one.
module scan_chain_engine #(
  parameter int NUM_DESIGNS = 8,
  parameter int IO_WIDTH    = 8,
  parameter int WS_WIDTH    = 8,
  parameter int SEL_W       = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [SEL_W-1:0]    active_select,
  input  logic [IO_WIDTH-1:0] in_data,
  input  logic [WS_WIDTH-1:0] ws_cfg,
  output logic                busy,
  output logic                done,
  output logic                sel_err,
  output logic [IO_WIDTH-1:0] out_data,
  output logic                scan_clk_out,
  output logic                scan_data_out,
  output logic                scan_select,
  output logic                scan_latch_en,
`ifdef SCAN_CHANGE_DETECT_EN
  output logic                out_changed,
`endif
  input  logic                scan_data_in
);

  localparam int BW = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(IO_WIDTH - 1);
  localparam logic [SEL_W:0]   NUM_D    = (SEL_W + 1)'(NUM_DESIGNS);
  localparam logic [SEL_W-1:0] DES_LAST = SEL_W'(NUM_DESIGNS - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_IN_LOAD,
    ST_IN_SHIFT_LO,
    ST_IN_SHIFT_HI,
    ST_IN_LATCH_WAIT,
    ST_IN_LATCH,
    ST_OUT_LOAD_PRE,
    ST_OUT_LOAD,
    ST_OUT_LOAD_POST,
    ST_OUT_LOAD_CLR,
    ST_OUT_SHIFT_LO,
    ST_OUT_SHIFT_HI,
    ST_OUT_CAP_WAIT,
    ST_OUT_CAP
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    des_cnt;
  logic [WS_WIDTH-1:0] ws_q;
  logic [WS_WIDTH-1:0] ws_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [IO_WIDTH-1:0] in_sr;
  logic [IO_WIDTH-1:0] out_sr;
  logic                sel_bad;
  logic                ws_done;
  logic                word_last;
  logic                in_last;
  logic                out_last;
  logic                in_wait;

  assign sel_bad   = {1'b0, active_select} >= NUM_D;
  assign ws_done   = (ws_cnt == ws_q);
  assign word_last = (bit_cnt == BIT_LAST);
  // Input stops once design sel is filled; readout stops after the word of design sel arrives.
  assign in_last   = word_last && (des_cnt == sel_q);
  assign out_last  = word_last && (des_cnt == (DES_LAST - sel_q));
  assign in_wait   = state inside {ST_IN_LATCH_WAIT, ST_OUT_LOAD_PRE, ST_OUT_LOAD_POST,
                                   ST_OUT_LOAD_CLR, ST_OUT_CAP_WAIT};
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:          if (start || continuous) state_nxt = ST_IN_LOAD;
      ST_IN_LOAD:       state_nxt = sel_bad ? ST_IDLE : ST_IN_SHIFT_LO;
      ST_IN_SHIFT_LO:   state_nxt = ST_IN_SHIFT_HI;
      ST_IN_SHIFT_HI:   state_nxt = in_last ? ST_IN_LATCH_WAIT : ST_IN_SHIFT_LO;
      ST_IN_LATCH_WAIT: if (ws_done) state_nxt = ST_IN_LATCH;
      ST_IN_LATCH:      state_nxt = ST_OUT_LOAD_PRE;
      ST_OUT_LOAD_PRE:  if (ws_done) state_nxt = ST_OUT_LOAD;
      ST_OUT_LOAD:      state_nxt = ST_OUT_LOAD_POST;
      ST_OUT_LOAD_POST: if (ws_done) state_nxt = ST_OUT_LOAD_CLR;
      ST_OUT_LOAD_CLR:  if (ws_done) state_nxt = ST_OUT_SHIFT_LO;
      ST_OUT_SHIFT_LO:  state_nxt = ST_OUT_SHIFT_HI;
      ST_OUT_SHIFT_HI:  state_nxt = out_last ? ST_OUT_CAP_WAIT : ST_OUT_SHIFT_LO;
      ST_OUT_CAP_WAIT:  if (ws_done) state_nxt = ST_OUT_CAP;
      ST_OUT_CAP:       state_nxt = ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Chain-facing outputs are decoded from the current state one cycle late, so they are glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q         <= '0;
      des_cnt       <= '0;
      ws_q          <= '0;
      ws_cnt        <= '0;
      bit_cnt       <= '0;
      in_sr         <= '0;
      out_sr        <= '0;
      out_data      <= '0;
      done          <= 1'b0;
      sel_err       <= 1'b0;
      scan_clk_out  <= 1'b0;
      scan_data_out <= 1'b0;
      scan_select   <= 1'b0;
      scan_latch_en <= 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
      out_changed   <= 1'b0;
`endif
    end else begin
      ws_cnt        <= (in_wait && !ws_done) ? ws_cnt + 1'b1 : '0;
      done          <= (state == ST_OUT_CAP);
      sel_err       <= (state == ST_IN_LOAD) && sel_bad;
      scan_clk_out  <= state inside {ST_IN_SHIFT_HI, ST_OUT_LOAD, ST_OUT_SHIFT_HI};
      scan_select   <= state inside {ST_OUT_LOAD_PRE, ST_OUT_LOAD, ST_OUT_LOAD_POST};
      scan_latch_en <= (state == ST_IN_LATCH);
      scan_data_out <= (state inside {ST_IN_SHIFT_LO, ST_IN_SHIFT_HI}) ? in_sr[IO_WIDTH-1] : 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
      out_changed   <= 1'b0;
`endif
      case (state)
        ST_IN_LOAD: begin
          sel_q   <= active_select;
          ws_q    <= ws_cfg;
          in_sr   <= in_data;
          bit_cnt <= '0;
          des_cnt <= '0;
        end
        ST_IN_SHIFT_HI: begin
          in_sr   <= {in_sr[IO_WIDTH-2:0], 1'b0};
          bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
          if (word_last) des_cnt <= des_cnt + 1'b1;
        end
        ST_OUT_LOAD_CLR: begin
          bit_cnt <= '0;
          des_cnt <= '0;
        end
        ST_OUT_SHIFT_HI: begin
          out_sr  <= {out_sr[IO_WIDTH-2:0], scan_data_in};
          bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
          if (word_last) des_cnt <= des_cnt + 1'b1;
        end
        ST_OUT_CAP: begin
          out_data <= out_sr;
`ifdef SCAN_CHANGE_DETECT_EN
          out_changed <= (out_sr != out_data);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
